semitone_search_arbiter: RTL and testbench

//  Shares one semitone searcher (start_search/search_val in, closest_value/closest_value_found out)

---
 rtl/semitone_pkg.sv | 14 +
 rtl/semitone_search_arbiter_picker.sv | 34 +++
 rtl/semitone_search_arbiter.sv | 130 +++++++++++++
 tb/tb_semitone_search_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/semitone_pkg.sv
// Shared types for the semitone search arbiter.
// Holds the default word width and the arbiter FSM encoding.
package semitone_pkg;

    localparam int WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/semitone_search_arbiter_picker.sv
// Round-robin priority picker: first request after ptr, wrapping.
// Purely combinational; grant is one-hot, index is its position.
module rr_priority_picker
    import semitone_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] index_o,
    output logic          any_o
);

    int idx;

    always_comb begin
        grant_o = '0;
        index_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        // Scan ptr+1 .. ptr so the last winner has lowest priority
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                index_o      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/semitone_search_arbiter.sv
// Shares one semitone searcher among N_REQ requesters with
// round-robin grant, a single search in flight and a timeout guard.
module semitone_search_arbiter
    import semitone_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_val,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [WIDTH-1:0]            resp_val,
    output logic                        resp_timeout,
    output logic                        srch_start,
    output logic [WIDTH-1:0]            srch_val,
    input  logic [WIDTH-1:0]            srch_result,
    input  logic                        srch_found,
    output logic                        busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [WIDTH-1:0] sval_q, sval_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             tmo_q, tmo_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             found_q;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             completion;

    rr_priority_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_picker (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .index_o (pick_idx),
        .any_o   (pick_any)
    );

    // Rising edge only: the searcher may hold found for several cycles
    assign completion = srch_found & ~found_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        sval_d   = sval_q;
        result_d = result_q;
        tmo_d    = tmo_q;
        timer_d  = timer_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sval_d  = req_val[pick_idx];
                    gidx_d  = pick_idx;
                    ptr_d   = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (completion) begin
                    result_d = srch_result;
                    tmo_d    = 1'b0;
                    state_d  = RESP;
                end else if (timer_q == TLAST) begin
                    result_d = '0;
                    tmo_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(N_REQ - 1);
            gidx_q   <= '0;
            sval_q   <= '0;
            result_q <= '0;
            tmo_q    <= 1'b0;
            timer_q  <= '0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            sval_q   <= sval_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
            timer_q  <= timer_d;
            found_q  <= srch_found;
        end
    end

    assign req_ready    = (state_q == IDLE && !rst_in) ? pick_grant : '0;
    assign resp_valid   = (state_q == RESP) ? (N_REQ'(1) << gidx_q) : '0;
    assign resp_val     = (state_q == RESP) ? result_q : '0;
    assign resp_timeout = (state_q == RESP) & tmo_q;
    assign srch_start   = (state_q == ISSUE);
    assign srch_val     = sval_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_semitone_search_arbiter.sv
// Randomised scoreboard bench for semitone_search_arbiter with a
// behavioural searcher (found after D cycles, held for two).
module tb_semitone_search_arbiter;
    import semitone_pkg::*;

    localparam int N     = 4;
    localparam int W     = 12;
    localparam int TO    = 64;
    localparam int NEVER = 100000;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid, req_ready, resp_valid;
    logic [N-1:0][W-1:0] req_val;
    logic [W-1:0]        resp_val, srch_val, srch_result;
    logic                resp_timeout, srch_start, srch_found, busy;

    always #5 clk = ~clk;

    semitone_search_arbiter #(
        .N_REQ          (N),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .req_valid    (req_valid),
        .req_val      (req_val),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_val     (resp_val),
        .resp_timeout (resp_timeout),
        .srch_start   (srch_start),
        .srch_val     (srch_val),
        .srch_result  (srch_result),
        .srch_found   (srch_found),
        .busy         (busy)
    );

    function automatic logic [W-1:0] quant(input logic [W-1:0] v);
        return {v[W-1:2], 2'b00};
    endfunction

    int       cyc = 0;
    logic     act = 1'b0;
    int       st = 0, sd = NEVER, d_pend = NEVER;
    logic [W-1:0] sres = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) act <= 1'b0;
        else if (srch_start) begin
            act  <= 1'b1;
            st   <= cyc;
            sd   <= d_pend;
            sres <= quant(srch_val);
        end
    end

    assign srch_found  = act && (cyc - st >= sd) && (cyc - st <= sd + 1);
    assign srch_result = sres;

    typedef struct {
        int           g;
        logic [W-1:0] v;
        logic         to;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    int           gl[$];
    int           n_chk = 0, n_fail = 0;
    logic         mon_en = 1'b0;
    logic         rst_drv;
    logic [N-1:0] pend;
    logic [W-1:0] pval[N];
    logic [W-1:0] sval_m;
    int           ptr_m = N - 1, t_hs = -10, due_m = -10, d_cfg = 10;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     nm, a, e, cyc);
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        int g, d;
        @(negedge clk);
        rst       = rst_drv;
        req_valid = pend;
        for (int i = 0; i < N; i++) req_val[i] = pval[i];
        #1;
        exp_rdy = '0;
        g = -1;
        if (!rst_drv && cyc > due_m)
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (ptr_m + k) % N;
                if (g < 0 && pend[i]) g = i;
            end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        if (rst_drv) begin
            sbq.delete();
            ptr_m = N - 1;
            t_hs  = -10;
            due_m = -10;
        end else begin
            chk("busy", busy, (cyc > t_hs && cyc <= due_m));
            chk("srch_start", srch_start, cyc == t_hs + 1);
            if (cyc == t_hs + 1) chk("srch_val", srch_val, sval_m);
            if (g >= 0) begin
                d      = d_cfg;
                d_pend = d;
                t_hs   = cyc;
                due_m  = cyc + ((d <= TO) ? d : TO) + 2;
                sval_m = pval[g];
                sbq.push_back('{g, (d <= TO) ? quant(pval[g]) : '0,
                                d > TO, due_m});
                gl.push_back(g);
                ptr_m   = g;
                pend[g] = 1'b0;
            end
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((pend != 0 || sbq.size() != 0 || cyc <= due_m) && n < max) begin
            step();
            n++;
        end
        if (n >= max) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_budget: %0d cycles used, limit %0d", n, max);
            pend = '0;
        end
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (resp_valid !== '0) begin
                if (sbq.size() == 0) chk("resp_unexpected", resp_valid, 0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_onehot", resp_valid, 1 << e.g);
                    chk("resp_val", resp_val, e.v);
                    chk("resp_timeout", resp_timeout, e.to);
                    chk("resp_cycle", cyc, e.due);
                end
            end else begin
                chk("resp_idle", {resp_timeout, resp_val}, 0);
                if (sbq.size() > 0 && cyc > sbq[0].due) begin
                    chk("resp_missing", resp_valid, 1 << sbq[0].g);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        rst_drv   = 1'b1;
        pend      = '0;
        req_valid = '0;
        req_val   = '0;
        for (int i = 0; i < N; i++) pval[i] = '0;
        step();
        step();
        rst_drv = 1'b0;
        step();
        mon_en = 1'b1;
        chk("rst_srch_val", srch_val, 0);
        chk("rst_resp", {resp_valid, resp_timeout}, 0);

        pval[2] = W'(440);
        pend[2] = 1'b1;
        d_cfg   = 20;
        drain(200);
        chk("single_grant", gl[gl.size()-1], 2);

        do_reset();
        gl.delete();
        for (int n = 0; n < 2000 && gl.size() < 8; n++) begin
            pend  = '1;
            d_cfg = $urandom_range(30, 3);
            for (int i = 0; i < N; i++) pval[i] = W'($urandom);
            step();
        end
        pend = '0;
        drain(200);
        for (int k = 0; k < 8; k++)
            chk("fair_order", (k < gl.size()) ? gl[k] : -1, k % 4);

        d_cfg   = NEVER;
        pval[1] = W'($urandom);
        pend[1] = 1'b1;
        drain(300);
        d_cfg   = 15;
        pend[0] = 1'b1;
        drain(200);

        foreach (pval[i]) pval[i] = W'($urandom);
        for (int d = TO - 1; d <= TO + 1; d++) begin
            d_cfg   = d;
            pend[3] = 1'b1;
            drain(300);
        end

        d_cfg   = 40;
        pend[3] = 1'b1;
        step();
        repeat (20) step();
        do_reset();
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_srch_val", srch_val, 0);
        gl.delete();
        pend = 4'b0011;
        drain(300);
        chk("post_rst_first", gl.size() > 0 ? gl[0] : -1, 0);
        do_reset();
        gl.delete();
        pend = 4'b0010;
        drain(300);
        chk("post_rst_only1", gl.size() > 0 ? gl[0] : -1, 1);

        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(5, 0) == 0) begin
                    pend[i] = 1'b1;
                    pval[i] = W'($urandom);
                end else if (pend[i] && $urandom_range(19, 0) == 0) begin
                    pend[i] = 1'b0;
                end else if ($urandom_range(9, 0) == 0) begin
                    pval[i] = W'($urandom);
                end
            end
            d_cfg = ($urandom_range(99, 0) == 0) ? NEVER : $urandom_range(70, 1);
            step();
        end
        pend = '0;
        drain(400);
        chk("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
